// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end with in-order request tracking and response buffer
module ifetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  // CW holds 0..MAX_OUTSTANDING, IW indexes MAX_OUTSTANDING slots
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW:0]   MAX_W    = (CW+1)'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_OUTSTANDING - 1);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  // PC of each accepted request, popped as its response returns
  logic [31:0]   tag_pc [MAX_OUTSTANDING];
  logic [IW-1:0] tag_wr;
  logic [IW-1:0] tag_rd;

  // Response buffer, entries {pc, inst}
  logic [31:0]   fifo_pc   [MAX_OUTSTANDING];
  logic [31:0]   fifo_inst [MAX_OUTSTANDING];
  logic [IW-1:0] f_wr;
  logic [IW-1:0] f_rd;
  logic [CW-1:0] f_cnt;

  logic [CW:0] inflight_total;
  logic        credit_ok;
  logic        req_accept;
  logic        resp_fire;
  logic        resp_drop;
  logic        fifo_push;
  logic        fifo_pop;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // Credit covers requests in flight plus responses already buffered, so the buffer can never overflow
  assign inflight_total = {1'b0, outstanding} + {1'b0, f_cnt};
  assign credit_ok      = inflight_total < MAX_W;

  // Outputs are gated by reset so they fall immediately when reset asserts
  assign imem_req_valid = reset && !redirect && credit_ok;
  assign imem_req_addr  = pc;
  assign req_accept     = imem_req_valid && imem_req_ready;

  // A response in a redirect cycle, or while stale responses remain, is thrown away
  assign resp_fire = reset && imem_resp_valid;
  assign resp_drop = redirect || (drop_cnt != '0);
  assign fifo_push = resp_fire && !resp_drop;

  assign if_valid = reset && (f_cnt != '0) && !redirect;
  assign fifo_pop = if_valid && !stall;
  assign if_pc    = if_valid ? fifo_pc[f_rd]   : 32'h0;
  assign if_inst  = if_valid ? fifo_inst[f_rd] : 32'h0;

  // Control state: pc, credit counters, queue pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      f_wr        <= '0;
      f_rd        <= '0;
      f_cnt       <= '0;
    end else begin
      if (redirect) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (req_accept) begin
        pc <= pc + 32'd4;
      end

      if (req_accept && !resp_fire) begin
        outstanding <= outstanding + 1'b1;
      end else if (!req_accept && resp_fire) begin
        outstanding <= outstanding - 1'b1;
      end

      if (req_accept) begin
        tag_wr <= next_idx(tag_wr);
      end
      if (resp_fire) begin
        tag_rd <= next_idx(tag_rd);
      end

      // Every request still in flight is stale after a redirect; drop_cnt is already
      // a subset of outstanding, so it is replaced rather than added to.
      if (redirect) begin
        drop_cnt <= outstanding - CW'(resp_fire);
      end else if (resp_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - 1'b1;
      end

      if (redirect) begin
        f_wr  <= '0;
        f_rd  <= '0;
        f_cnt <= '0;
      end else begin
        if (fifo_push) begin
          assert (f_cnt != FULL_CNT) else $error("ifetch_unit: response fifo overflow");
          f_wr <= next_idx(f_wr);
        end
        if (fifo_pop) begin
          f_rd <= next_idx(f_rd);
        end
        if (fifo_push && !fifo_pop) begin
          f_cnt <= f_cnt + 1'b1;
        end else if (!fifo_push && fifo_pop) begin
          f_cnt <= f_cnt - 1'b1;
        end
      end
    end
  end

  // Queue payload storage; validity is tracked by the pointers above
  always_ff @(posedge clk) begin
    if (req_accept) begin
      tag_pc[tag_wr] <= pc;
    end
    if (fifo_push) begin
      fifo_pc[f_wr]   <= tag_pc[tag_rd];
      fifo_inst[f_wr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed and random scoreboard bench for ifetch_unit
module tb_ifetch_unit;

  localparam int          MAX = 2;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int out_m = 0;
  int last_due = 0;
  int lat_min = 1;
  int lat_max = 1;
  int pops = 0;
  bit rand_mode = 0;
  bit held = 0;
  logic [31:0] held_pc;
  logic [31:0] held_inst;
  logic [31:0] exp_req_pc = 32'h0;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] sb_q[$];

  ifetch_unit #(.RESET_PC(32'h0000_0000), .MAX_OUTSTANDING(MAX)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge: set core inputs and present the memory response head
  task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
    stall = s;
    redirect = r;
    redirect_pc = rpc;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = mem_addr_q[0] ^ KEY;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data = 32'h0;
    end
    #1;
  endtask

  // Observe settled outputs, update memory model and scoreboard, advance one cycle
  task automatic finish_cycle();
    logic [31:0] exp_pc;
    int lat;
    if (imem_req_valid) check("credit", 32'(out_m < MAX), 32'd1);
    if (redirect) begin
      check("redir_ifv", 32'(if_valid), 32'd0);
      check("redir_reqv", 32'(imem_req_valid), 32'd0);
    end
    if (held && !redirect) begin
      check("hold_ifv", 32'(if_valid), 32'd1);
      check("hold_pc", if_pc, held_pc);
      check("hold_inst", if_inst, held_inst);
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req_pc);
      lat = int'($urandom_range(lat_min, lat_max));
      if (cyc + lat > last_due) last_due = cyc + lat;
      mem_addr_q.push_back(imem_req_addr);
      mem_due_q.push_back(last_due);
      sb_q.push_back(imem_req_addr);
      exp_req_pc = exp_req_pc + 32'd4;
      out_m++;
    end
    if (imem_resp_valid) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
      out_m--;
    end
    if (if_valid && !stall) begin
      total++;
      assert (sb_q.size() > 0) else begin
        bad++;
        $error("FAIL sb_underflow observed=%h expected=none", if_pc);
      end
      if (sb_q.size() > 0) begin
        exp_pc = sb_q.pop_front();
        check("if_pc", if_pc, exp_pc);
        check("if_inst", if_inst, exp_pc ^ KEY);
      end
      pops++;
    end
    held = if_valid && stall && !redirect;
    held_pc = if_pc;
    held_inst = if_inst;
    if (redirect) begin
      sb_q.delete();
      exp_req_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    imem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    drive(s, r, rpc);
    finish_cycle();
  endtask

  task automatic run_until_pop(output logic [31:0] pc, output bit ok);
    ok = 0;
    pc = 32'h0;
    for (int i = 0; i < 40 && !ok; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (if_valid) begin
        pc = if_pc;
        ok = 1;
      end
      finish_cycle();
    end
  endtask

  initial begin
    logic [31:0] pc;
    bit ok;
    bit found;
    int pops_before;

    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_ifv", 32'(if_valid), 32'd0);
    check("rst_reqv", 32'(imem_req_valid), 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Startup latency: first instruction presented after the second edge
    drive(1'b0, 1'b0, 32'h0);
    check("start_reqv", 32'(imem_req_valid), 32'd1);
    check("start_ifv_c0", 32'(if_valid), 32'd0);
    finish_cycle();
    drive(1'b0, 1'b0, 32'h0);
    check("start_ifv_c1", 32'(if_valid), 32'd0);
    finish_cycle();
    drive(1'b0, 1'b0, 32'h0);
    check("start_ifv_c2", 32'(if_valid), 32'd1);
    check("start_pc", if_pc, 32'h0);
    check("start_inst", if_inst, 32'hA5A5_0000);
    finish_cycle();

    // Stall while pc 8 is presented
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (if_valid && if_pc == 32'h8) found = 1;
      else finish_cycle();
    end
    check("found_pc8", 32'(found), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      check("stall_pc", if_pc, 32'h8);
      check("stall_inst", if_inst, 32'hA5A5_0008);
      if (i == 2) check("stall_reqv", 32'(imem_req_valid), 32'd0);
      finish_cycle();
    end
    run_until_pop(pc, ok);
    check("resume_ok", 32'(ok), 32'd1);
    check("resume_pc", pc, 32'h8);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    // Redirect with two requests in flight
    lat_min = 3;
    lat_max = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (out_m == 2) found = 1;
      else finish_cycle();
    end
    check("found_out2", 32'(found), 32'd1);
    drive(1'b0, 1'b1, 32'h100);
    finish_cycle();
    run_until_pop(pc, ok);
    check("redir_ok", 32'(ok), 32'd1);
    check("redir_pc", pc, 32'h100);

    // Redirect coinciding with a response, then a second redirect
    lat_min = 2;
    lat_max = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (imem_resp_valid) found = 1;
      else finish_cycle();
    end
    check("found_resp", 32'(found), 32'd1);
    drive(1'b0, 1'b1, 32'h180);
    finish_cycle();
    step(1'b0, 1'b1, 32'h200);
    run_until_pop(pc, ok);
    check("dbl_ok", 32'(ok), 32'd1);
    check("dbl_pc", pc, 32'h200);

    // PC wrap; low redirect bits ignored
    lat_min = 1;
    lat_max = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    run_until_pop(pc, ok);
    check("wrap_pc0", pc, 32'hFFFF_FFFC);
    run_until_pop(pc, ok);
    check("wrap_pc1", pc, 32'h0);

    // Asynchronous reset in the middle of traffic
    lat_min = 2;
    lat_max = 2;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    check("pre_rst_ifv", 32'(if_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_ifv", 32'(if_valid), 32'd0);
    check("mid_rst_reqv", 32'(imem_req_valid), 32'd0);
    check("mid_rst_pc", if_pc, 32'h0);
    check("mid_rst_inst", if_inst, 32'h0);
    mem_addr_q.delete();
    mem_due_q.delete();
    sb_q.delete();
    out_m = 0;
    last_due = 0;
    held = 0;
    exp_req_pc = 32'h0;
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    imem_req_ready = 1'b1;
    run_until_pop(pc, ok);
    check("post_rst_ok", 32'(ok), 32'd1);
    check("post_rst_pc", pc, 32'h0);

    // Random ready, latency, stall and redirect
    rand_mode = 1;
    lat_min = 1;
    lat_max = 5;
    pops_before = pops;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 29) == 0), $urandom);
    end
    check("rand_progress", 32'(pops > pops_before + 40), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
